// File: rtl/vehicle_classifier.sv
`default_nettype none
// ============================================================================
// Module   : vehicle_classifier
// Brief    : Road-loop front end: synchronises and debounces the raw loop
//            sensor, measures occupancy length and emits one Bike/Car token
//            per vehicle, with a fault strobe for over-long occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module vehicle_classifier #(
    parameter int DEBOUNCE    = 4,
    parameter int CAR_MIN_LEN = 16,
    parameter int MAX_LEN     = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sensor_in,
    output logic        d_out,
    output logic        valid_out,
    output logic        fault,
    output logic        busy,
    output logic [15:0] veh_count
);

    // Sized so DEBOUNCE-1 always fits, including DEBOUNCE == 1.
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [DB_W-1:0]  c_DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_CAR_MIN = CNT_W'(CAR_MIN_LEN);
    localparam logic [CNT_W-1:0] c_LEN_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OCC   = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    logic            r_sync_meta;
    logic            r_sync_q;
    logic            r_filt;
    logic [DB_W-1:0] r_db_cnt;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic            r_d_out;
    logic            w_d_out_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_fault;
    logic            w_fault_nxt;
    logic [15:0]     r_veh_count;
    logic [15:0]     w_veh_count_nxt;

    // Two-flop synchroniser for the asynchronous loop sensor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync_q    <= 1'b0;
        end else begin
            r_sync_meta <= sensor_in;
            r_sync_q    <= r_sync_meta;
        end
    end

    // Rise and fall are both accepted after DEBOUNCE stable cycles, so the
    // filtered high-run length equals the raw high-run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt   <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync_q == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_filt   <= r_sync_q;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_d_out     <= 1'b0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_veh_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_d_out     <= w_d_out_nxt;
            r_valid     <= w_valid_nxt;
            r_fault     <= w_fault_nxt;
            r_veh_count <= w_veh_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_d_out_nxt     = r_d_out;
        w_valid_nxt     = 1'b0;
        w_fault_nxt     = 1'b0;
        w_veh_count_nxt = r_veh_count;

        case (r_state)
            S_IDLE: begin
                if (r_filt) begin
                    w_state_nxt = S_OCC;
                    w_len_nxt   = c_LEN_ONE;
                end
            end
            S_OCC: begin
                if (!r_filt) begin
                    w_state_nxt     = S_IDLE;
                    w_valid_nxt     = 1'b1;
                    w_d_out_nxt     = (r_len >= c_CAR_MIN);
                    w_veh_count_nxt = r_veh_count + 16'd1;
                end else if (r_len == c_MAX_LEN) begin
                    w_state_nxt = S_STUCK;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_len_nxt = r_len + 1'b1;
                end
            end
            S_STUCK: begin
                // A stuck occupancy is dropped; only a fresh rise counts again.
                if (!r_filt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign d_out     = r_d_out;
    assign valid_out = r_valid;
    assign fault     = r_fault;
    assign veh_count = r_veh_count;
    assign busy      = (r_state == S_OCC) || (r_state == S_STUCK);

endmodule
`default_nettype wire

// File: tb/tb_vehicle_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_vehicle_classifier
// Brief    : Scoreboard bench for vehicle_classifier; expected tokens/faults
//            come from a run-length model of the sensor waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vehicle_classifier;

    localparam int c_DEBOUNCE = 4;
    localparam int c_CAR_MIN  = 16;
    localparam int c_MAX_LEN  = 64;
    localparam int c_LATENCY  = 2 + c_DEBOUNCE + 1;

    logic        clk;
    logic        rst;
    logic        sensor_in;
    logic        d_out;
    logic        valid_out;
    logic        fault;
    logic        busy;
    logic [15:0] veh_count;

    vehicle_classifier #(
        .DEBOUNCE    (c_DEBOUNCE),
        .CAR_MIN_LEN (c_CAR_MIN),
        .MAX_LEN     (c_MAX_LEN),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_in (sensor_in),
        .d_out     (d_out),
        .valid_out (valid_out),
        .fault     (fault),
        .busy      (busy),
        .veh_count (veh_count)
    );

    typedef struct {
        bit          is_fault;
        bit          car;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] model_cnt = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a high-run of N cycles gives nothing if N < DEBOUNCE, a token
    // (Car iff N >= CAR_MIN) if N <= MAX_LEN, otherwise a fault.
    task automatic run(input int n, input int gap);
        exp_t e;
        @(negedge clk);
        if (n >= c_DEBOUNCE) begin
            e.car = (n >= c_CAR_MIN);
            if (n > c_MAX_LEN) begin
                e.is_fault = 1'b1;
                e.cnt      = model_cnt;
                e.cyc      = cyc + c_LATENCY + c_MAX_LEN;
            end else begin
                model_cnt  = model_cnt + 16'd1;
                e.is_fault = 1'b0;
                e.cnt      = model_cnt;
                e.cyc      = cyc + n + c_LATENCY;
            end
            sb.push_back(e);
        end
        sensor_in = 1'b1;
        repeat (n) @(negedge clk);
        sensor_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_veh_count"}, veh_count, model_cnt);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (valid_out || fault)) begin
            check("strobe_exclusive", valid_out & fault, 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: valid=%0d fault=%0d d_out=%0d expected none (cycle %0d)",
                         valid_out, fault, d_out, cyc);
            end else begin
                e = sb.pop_front();
                check("kind_fault", fault, e.is_fault);
                check("strobe_cycle", cyc, e.cyc);
                check("veh_count", veh_count, e.cnt);
                if (!e.is_fault) check("d_out", d_out, e.car);
            end
        end
    end

    initial begin
        int bad;
        rst       = 1'b1;
        sensor_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid_out, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        check("rst_d_out", d_out, 0);
        check("rst_veh_count", veh_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed boundaries: bike, CAR_MIN-1, CAR_MIN, MAX_LEN, min pulse.
        run(10, 20);
        run(15, 20);
        run(16, 20);
        run(c_MAX_LEN, 20);
        run(c_DEBOUNCE, 20);
        drain("directed");

        // Sub-DEBOUNCE glitch must not even make the block busy.
        @(negedge clk);
        sensor_in = 1'b1;
        bad = 0;
        repeat (c_DEBOUNCE - 1) begin
            @(negedge clk);
            bad += busy;
        end
        sensor_in = 1'b0;
        repeat (15) begin
            @(negedge clk);
            bad += busy;
        end
        check("glitch_busy_cycles", bad, 0);

        // Over-long occupancy: fault, busy held until the fall, then recovery.
        run(c_MAX_LEN + 1, 2);
        check("stuck_busy_after_fall", busy, 1);
        repeat (20) @(negedge clk);
        check("stuck_busy_released", busy, 0);
        run(c_MAX_LEN + 30, 20);
        run(10, 20);
        run(8, 20);
        run(30, 20);
        run(30, 20);
        run(30, 20);
        run(8, 20);
        drain("fault_and_sequence");

        // Randomised runs, lengths spanning glitch..stuck.
        for (int i = 0; i < 40; i++) begin
            int n;
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, c_DEBOUNCE + 2);
                1:       n = $urandom_range(c_CAR_MIN - 2, c_CAR_MIN + 2);
                2:       n = $urandom_range(c_MAX_LEN - 2, c_MAX_LEN + 3);
                default: n = $urandom_range(1, 90);
            endcase
            run(n, $urandom_range(2 * c_DEBOUNCE, 30));
        end
        drain("random");

        // Reset mid-occupancy discards the vehicle.
        @(negedge clk);
        sensor_in = 1'b1;
        repeat (2 + c_DEBOUNCE + 12) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst       = 1'b1;
        sensor_in = 1'b0;
        model_cnt = '0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_veh_count", veh_count, 0);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_d_out", d_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        drain("post_rst");
        run(20, 20);
        drain("post_rst_car");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
